// File: rtl/cc_miss_fill_ctrl_pkg.sv
// Shared cache-controller types: address split, line geometry, fill FSM states, tag-SRAM entry.
// Latency: n/a (types only).
// Backpressure: n/a.
package cc_miss_fill_ctrl_pkg;

    localparam int TAG_W    = 18;
    localparam int INDEX_W  = 8;
    localparam int OFFSET_W = 6;
    localparam int LINE_W   = 512;
    localparam int MEM_DW   = 64;
    localparam int BEATS    = LINE_W / MEM_DW;
    localparam int WORD_W   = 32;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        FILL,
        WRITE,
        RESP
    } state_t;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
    } tag_entry_t;

endpackage

// File: rtl/cc_line_buffer.sv
// Line assembly buffer: beat counter, write-by-beat, word-select read.
// Latency: a beat is visible in the line the cycle after it is accepted; word read is combinational.
// Backpressure: none; beats beyond the line length are accepted and dropped.
module cc_line_buffer #(
    parameter int MEM_DW = 64,
    parameter int LINE_W = 512,
    parameter int WSEL_W = $clog2(LINE_W / 32)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              beat_vld,
    input  logic [MEM_DW-1:0] beat_dat,
    input  logic [WSEL_W-1:0] word_sel,
    output logic [LINE_W-1:0] line,
    output logic [31:0]       word
);

    localparam int NBEATS = LINE_W / MEM_DW;
    localparam int CNT_W  = $clog2(NBEATS) + 1;

    logic [CNT_W-1:0] cnt;

    // cnt saturates at NBEATS so overrun beats can never alias onto beat 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line <= '0;
            cnt  <= '0;
        end else if (clr) begin
            line <= '0;
            cnt  <= '0;
        end else if (beat_vld && (cnt < CNT_W'(NBEATS))) begin
            line[cnt[CNT_W-2:0]*MEM_DW +: MEM_DW] <= beat_dat;
            cnt                                   <= cnt + 1'b1;
        end
    end

    assign word = line[word_sel*32 +: 32];

endmodule

// File: rtl/cc_miss_fill_ctrl.sv
// Miss handler: latches the missing address, bursts one line from memory, writes tag+data SRAM, returns the word.
// Latency: miss -> AR next cycle; SRAM write 1 cycle after rlast beat; CPU response the cycle after that.
// Backpressure: waits on arready / rvalid / cpu_rready; busy_o stalls upstream for the whole fill.
module cc_miss_fill_ctrl #(
    parameter int MEM_DW = cc_miss_fill_ctrl_pkg::MEM_DW,
    parameter int LINE_W = cc_miss_fill_ctrl_pkg::LINE_W
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     miss_i,
    input  logic [cc_miss_fill_ctrl_pkg::TAG_W-1:0]    tag_i,
    input  logic [cc_miss_fill_ctrl_pkg::INDEX_W-1:0]  index_i,
    input  logic [cc_miss_fill_ctrl_pkg::OFFSET_W-1:0] offset_i,
    output logic                                     busy_o,
    output logic                                     mem_arvalid_o,
    input  logic                                     mem_arready_i,
    output logic [31:0]                              mem_araddr_o,
    output logic [3:0]                               mem_arlen_o,
    input  logic                                     mem_rvalid_i,
    output logic                                     mem_rready_o,
    input  logic [MEM_DW-1:0]                        mem_rdata_i,
    input  logic                                     mem_rlast_i,
    output logic                                     wren_o,
    output logic [cc_miss_fill_ctrl_pkg::INDEX_W-1:0]  windex_o,
    output logic [cc_miss_fill_ctrl_pkg::TAG_W:0]      wdata_tag_o,
    output logic [LINE_W-1:0]                        wdata_data_o,
    output logic                                     cpu_rvalid_o,
    input  logic                                     cpu_rready_i,
    output logic [31:0]                              cpu_rdata_o
);

    import cc_miss_fill_ctrl_pkg::*;

    localparam int NBEATS = LINE_W / MEM_DW;
    localparam int WSEL_W = OFFSET_W - 2;

    state_t              state_q, state_d;
    logic [TAG_W-1:0]    tag_q;
    logic [INDEX_W-1:0]  index_q;
    logic [WSEL_W-1:0]   wsel_q;
    logic                start_fill;
    logic                beat_acc;
    tag_entry_t          tag_entry;
    logic                unused_offset_lsb;

    assign unused_offset_lsb = ^offset_i[1:0];
    assign start_fill        = (state_q == IDLE) && miss_i;
    assign beat_acc          = (state_q == FILL) && mem_rvalid_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q   <= '0;
            index_q <= '0;
            wsel_q  <= '0;
        end else if (start_fill) begin
            tag_q   <= tag_i;
            index_q <= index_i;
            wsel_q  <= offset_i[OFFSET_W-1:2];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (miss_i)                   state_d = REQ;
            REQ:     if (mem_arready_i)            state_d = FILL;
            FILL:    if (mem_rvalid_i && mem_rlast_i) state_d = WRITE;
            WRITE:                                 state_d = RESP;
            RESP:    if (cpu_rready_i)             state_d = IDLE;
            default:                               state_d = IDLE;
        endcase
    end

    // Handshake outputs decode state only, so nothing from the memory inputs reaches them combinationally
    always_comb begin
        busy_o        = 1'b0;
        mem_arvalid_o = 1'b0;
        mem_rready_o  = 1'b0;
        wren_o        = 1'b0;
        cpu_rvalid_o  = 1'b0;
        case (state_q)
            REQ: begin
                busy_o        = 1'b1;
                mem_arvalid_o = 1'b1;
            end
            FILL: begin
                busy_o       = 1'b1;
                mem_rready_o = 1'b1;
            end
            WRITE: begin
                busy_o = 1'b1;
                wren_o = 1'b1;
            end
            RESP: begin
                busy_o       = 1'b1;
                cpu_rvalid_o = 1'b1;
            end
            default: ;
        endcase
    end

    cc_line_buffer #(
        .MEM_DW (MEM_DW),
        .LINE_W (LINE_W),
        .WSEL_W (WSEL_W)
    ) u_line_buffer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (start_fill),
        .beat_vld (beat_acc),
        .beat_dat (mem_rdata_i),
        .word_sel (wsel_q),
        .line     (wdata_data_o),
        .word     (cpu_rdata_o)
    );

    assign tag_entry.valid = (state_q == WRITE);
    assign tag_entry.tag   = tag_q;
    assign wdata_tag_o     = tag_entry;

    assign mem_araddr_o = {tag_q, index_q, 6'b0};
    assign mem_arlen_o  = 4'(NBEATS - 1);
    assign windex_o     = index_q;

endmodule

// File: tb/tb_cc_miss_fill_ctrl.sv
// Directed bench for cc_miss_fill_ctrl: table of fills plus hand-written reset-mid-fill sequence.
module tb_cc_miss_fill_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         miss_i;
    logic [17:0]  tag_i;
    logic [7:0]   index_i;
    logic [5:0]   offset_i;
    logic         busy_o;
    logic         mem_arvalid_o;
    logic         mem_arready_i;
    logic [31:0]  mem_araddr_o;
    logic [3:0]   mem_arlen_o;
    logic         mem_rvalid_i;
    logic         mem_rready_o;
    logic [63:0]  mem_rdata_i;
    logic         mem_rlast_i;
    logic         wren_o;
    logic [7:0]   windex_o;
    logic [18:0]  wdata_tag_o;
    logic [511:0] wdata_data_o;
    logic         cpu_rvalid_o;
    logic         cpu_rready_i;
    logic [31:0]  cpu_rdata_o;

    always #5 clk = ~clk;

    cc_miss_fill_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .miss_i        (miss_i),
        .tag_i         (tag_i),
        .index_i       (index_i),
        .offset_i      (offset_i),
        .busy_o        (busy_o),
        .mem_arvalid_o (mem_arvalid_o),
        .mem_arready_i (mem_arready_i),
        .mem_araddr_o  (mem_araddr_o),
        .mem_arlen_o   (mem_arlen_o),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rready_o  (mem_rready_o),
        .mem_rdata_i   (mem_rdata_i),
        .mem_rlast_i   (mem_rlast_i),
        .wren_o        (wren_o),
        .windex_o      (windex_o),
        .wdata_tag_o   (wdata_tag_o),
        .wdata_data_o  (wdata_data_o),
        .cpu_rvalid_o  (cpu_rvalid_o),
        .cpu_rready_i  (cpu_rready_i),
        .cpu_rdata_o   (cpu_rdata_o)
    );

    typedef struct {
        logic [17:0] tag;
        logic [7:0]  idx;
        logic [5:0]  off;
        logic [31:0] seed;
        int          nbeats;
        int          ar_stall;
        bit          r_gap;
        int          cpu_stall;
        bit          intruder;
        logic [31:0] exp_araddr;
        logic [18:0] exp_wtag;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [6];
    vec_t vrst;
    int   n_pass  = 0;
    int   n_total = 0;
    int   ar_cnt  = 0;
    int   wr_cnt  = 0;

    // Handshake counter, sampled mid-low-phase when inputs and outputs are both settled
    always begin
        @(negedge clk);
        #2;
        if (rst_n && mem_arvalid_o && mem_arready_i) ar_cnt++;
        if (rst_n && wren_o) wr_cnt++;
    end

    function automatic logic [63:0] beat_dat(input logic [31:0] seed, input int k);
        return {seed + 32'(k), 32'(k)};
    endfunction

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    task automatic check_zero(input string nm);
        chk({nm, ".busy"},       busy_o,        '0);
        chk({nm, ".arvalid"},    mem_arvalid_o, '0);
        chk({nm, ".rready"},     mem_rready_o,  '0);
        chk({nm, ".wren"},       wren_o,        '0);
        chk({nm, ".cpu_rvalid"}, cpu_rvalid_o,  '0);
        chk({nm, ".araddr"},     mem_araddr_o,  '0);
        chk({nm, ".windex"},     windex_o,      '0);
        chk({nm, ".wtag"},       wdata_tag_o,   '0);
        chk({nm, ".wdata"},      wdata_data_o,  '0);
        chk({nm, ".cpu_rdata"},  cpu_rdata_o,   '0);
    endtask

    task automatic run_fill(input vec_t v, input string nm);
        logic [511:0] mline;
        int           a0;
        int           w0;
        mline = '0;
        for (int k = 0; k < v.nbeats && k < 8; k++) mline[k*64 +: 64] = beat_dat(v.seed, k);
        a0 = ar_cnt;
        w0 = wr_cnt;

        @(negedge clk);
        chk({nm, ".idle_busy"}, busy_o, 1'b0);
        tag_i    = v.tag;
        index_i  = v.idx;
        offset_i = v.off;
        miss_i   = 1'b1;
        mem_arready_i = 1'b0;

        @(negedge clk);
        miss_i = 1'b0;
        chk({nm, ".arvalid"}, mem_arvalid_o, 1'b1);
        chk({nm, ".req_busy"}, busy_o, 1'b1);
        chk({nm, ".araddr"}, mem_araddr_o, v.exp_araddr);
        chk({nm, ".arlen"}, mem_arlen_o, 4'd7);
        for (int i = 0; i < v.ar_stall; i++) begin
            @(negedge clk);
            chk({nm, ".ar_hold_vld"}, mem_arvalid_o, 1'b1);
            chk({nm, ".ar_hold_addr"}, mem_araddr_o, v.exp_araddr);
        end
        mem_arready_i = 1'b1;

        @(negedge clk);
        mem_arready_i = 1'b0;
        chk({nm, ".fill_rready"}, mem_rready_o, 1'b1);
        chk({nm, ".fill_arvalid"}, mem_arvalid_o, 1'b0);

        for (int k = 0; k < v.nbeats; k++) begin
            if (v.r_gap && k == 1) begin
                mem_rvalid_i = 1'b0;
                @(negedge clk);
            end
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = beat_dat(v.seed, k);
            mem_rlast_i  = (k == v.nbeats - 1);
            if (v.intruder && k == 2) begin
                miss_i  = 1'b1;
                index_i = 8'h01;
            end
            @(negedge clk);
            miss_i = 1'b0;
        end
        mem_rvalid_i = 1'b0;
        mem_rlast_i  = 1'b0;

        chk({nm, ".wren"}, wren_o, 1'b1);
        chk({nm, ".windex"}, windex_o, v.idx);
        chk({nm, ".wtag"}, wdata_tag_o, v.exp_wtag);
        chk({nm, ".wdata"}, wdata_data_o, mline);
        chk({nm, ".write_rready"}, mem_rready_o, 1'b0);
        if (v.nbeats <= 4) chk({nm, ".upper_zero"}, wdata_data_o[511:256], '0);
        cpu_rready_i = (v.cpu_stall == 0);

        @(negedge clk);
        chk({nm, ".cpu_rvalid"}, cpu_rvalid_o, 1'b1);
        chk({nm, ".cpu_rdata"}, cpu_rdata_o, v.exp_rdata);
        chk({nm, ".resp_wren"}, wren_o, 1'b0);
        for (int i = 0; i < v.cpu_stall; i++) begin
            @(negedge clk);
            chk({nm, ".stall_rvalid"}, cpu_rvalid_o, 1'b1);
            chk({nm, ".stall_rdata"}, cpu_rdata_o, v.exp_rdata);
            chk({nm, ".stall_busy"}, busy_o, 1'b1);
        end
        cpu_rready_i = 1'b1;

        @(negedge clk);
        cpu_rready_i = 1'b0;
        chk({nm, ".done_busy"}, busy_o, 1'b0);
        chk({nm, ".done_rvalid"}, cpu_rvalid_o, 1'b0);
        chk({nm, ".ar_count"}, 32'(ar_cnt - a0), 32'd1);
        chk({nm, ".wr_count"}, 32'(wr_cnt - w0), 32'd1);
    endtask

    initial begin
        //          tag       idx    off    seed          nb stall gap cpu intr  araddr         wtag       rdata
        vecs[0] = '{18'h2ABCD, 8'h5A, 6'h14, 32'h0,        8, 0, 1'b0, 0, 1'b0, 32'hAAF3_5680, 19'h6ABCD, 32'h0000_0002};
        vecs[1] = '{18'h3FFFF, 8'hFF, 6'h3C, 32'h1000_0000, 8, 5, 1'b0, 0, 1'b0, 32'hFFFF_FFC0, 19'h7FFFF, 32'h1000_0007};
        vecs[2] = '{18'h00000, 8'h00, 6'h06, 32'hDEAD_0000, 8, 0, 1'b1, 3, 1'b0, 32'h0000_0000, 19'h40000, 32'hDEAD_0000};
        vecs[3] = '{18'h2ABCD, 8'h5A, 6'h3C, 32'h0,        4, 0, 1'b0, 0, 1'b0, 32'hAAF3_5680, 19'h6ABCD, 32'h0000_0000};
        vecs[4] = '{18'h12345, 8'h80, 6'h20, 32'h5000_0000, 10, 0, 1'b0, 0, 1'b0, 32'h48D1_6000, 19'h52345, 32'h0000_0004};
        vecs[5] = '{18'h2ABCD, 8'h5A, 6'h14, 32'h0,        8, 0, 1'b0, 0, 1'b1, 32'hAAF3_5680, 19'h6ABCD, 32'h0000_0002};
        vrst    = '{18'h00001, 8'h02, 6'h0C, 32'h7000_0000, 2, 0, 1'b0, 0, 1'b0, 32'h0000_4080, 19'h40001, 32'h7000_0001};

        rst_n         = 1'b0;
        miss_i        = 1'b0;
        tag_i         = '0;
        index_i       = '0;
        offset_i      = '0;
        mem_arready_i = 1'b0;
        mem_rvalid_i  = 1'b0;
        mem_rdata_i   = '0;
        mem_rlast_i   = 1'b0;
        cpu_rready_i  = 1'b0;

        repeat (2) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) run_fill(vecs[i], $sformatf("vec%0d", i));

        // Abandon a fill after 4 beats with an asynchronous reset
        @(negedge clk);
        tag_i    = 18'h2ABCD;
        index_i  = 8'h5A;
        offset_i = 6'h14;
        miss_i   = 1'b1;
        mem_arready_i = 1'b1;
        @(negedge clk);
        miss_i = 1'b0;
        @(negedge clk);
        mem_arready_i = 1'b0;
        chk("rstmid.in_fill", mem_rready_o, 1'b1);
        for (int k = 0; k < 4; k++) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = beat_dat(32'h0, k) | 64'hFFFF_0000_FFFF_0000;
            mem_rlast_i  = 1'b0;
            @(negedge clk);
        end
        mem_rvalid_i = 1'b0;
        #1 rst_n = 1'b0;
        #1 check_zero("rstmid");
        @(negedge clk);
        rst_n = 1'b1;
        run_fill(vrst, "after_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cc_miss_fill_ctrl.md
Name: cc_miss_fill_ctrl

Overview:
Miss-handling stage directly downstream of the tag comparator in the direct-mapped cache controller (18-bit tag, 8-bit index, 6-bit offset, 64-byte lines).
- On a miss pulse it latches the delayed tag, index and offset.
- It issues one line-aligned burst read to memory over an AXI-style AR/R channel.
- It assembles the line and writes the data SRAM and the tag SRAM (valid bit plus tag) in one cycle.
- It then returns the requested 32-bit word to the CPU and holds busy so that upstream stalls.

Parameters:
MEM_DW, 64, memory read-data width in bits.
LINE_W, 512, cache line width in bits (BEATS = LINE_W/MEM_DW = 8).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
miss_i  in  1  single-cycle miss pulse from the tag comparator
tag_i  in  18  delayed tag
index_i  in  8  delayed index
offset_i  in  6  delayed offset
busy_o  out  1  fill in progress; upstream stalls
mem_arvalid_o  out  1  read address valid
mem_arready_i  in  1  read address ready
mem_araddr_o  out  32  {tag,index,6'b0}
mem_arlen_o  out  4  constant BEATS-1 (7)
mem_rvalid_i  in  1  read data valid
mem_rready_o  out  1  read data ready
mem_rdata_i  in  MEM_DW  read data beat
mem_rlast_i  in  1  last beat
wren_o  out  1  SRAM write enable (tag and data)
windex_o  out  8  SRAM write index
wdata_tag_o  out  19  {1'b1, tag}
wdata_data_o  out  LINE_W  assembled line
cpu_rvalid_o  out  1  response valid
cpu_rready_i  in  1  response ready
cpu_rdata_o  out  32  requested word

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - State is IDLE.
  - All outputs are 0, including busy_o, mem_arvalid_o, mem_rready_o, wren_o and cpu_rvalid_o.
  - Line buffer, latched tag/index/offset and beat counter are 0.
- IDLE:
  - busy_o=0.
  - When miss_i=1, latch tag_i, index_i and offset_i, clear the line buffer and the beat counter, and go to REQ.
- REQ:
  - busy_o=1 and mem_arvalid_o=1.
  - mem_araddr_o and mem_arlen_o are stable while waiting.
  - On mem_arvalid_o & mem_arready_i, go to FILL.
- FILL:
  - mem_rready_o=1.
  - Each accepted beat (rvalid & rready) is written to line bits [cnt*MEM_DW +: MEM_DW], then cnt increments.
  - Beats arriving after cnt reaches BEATS are accepted and discarded.
  - The beat carrying mem_rlast_i completes the fill and goes to WRITE.
  - If rlast arrives early, the remaining words stay 0.
- WRITE:
  - One cycle with wren_o=1, windex_o equal to the latched index, wdata_tag_o={1'b1,tag} and wdata_data_o equal to the line.
  - Next state is RESP.
- RESP:
  - cpu_rvalid_o=1 and cpu_rdata_o = line[offset[5:2]*32 +: 32].
  - cpu_rdata_o is stable until handshake.
  - On cpu_rvalid_o & cpu_rready_i, go to IDLE.
  - busy_o deasserts in that same cycle (combinational off state==IDLE next cycle; registered is acceptable if it drops the cycle after the handshake).
- Latency with ready always high: miss at cycle 0 → arvalid at cycle 1 → first beat earliest at cycle 2 → write one cycle after the rlast beat → cpu_rvalid the cycle after that.
- miss_i while busy_o=1 is ignored; upstream guarantees no overlap.
- Inputs arriving in the same cycle are registered only in the state-appropriate cycle, and no combinational path runs from memory inputs to memory outputs.
- Reset mid-operation returns to IDLE immediately. Any outstanding burst is abandoned; the memory side is reset with the same rst_n.
- offset_i[1:0] is ignored; accesses are word-aligned.

Decomposition:
- The shared cache-controller package holds:
  - TAG_W=18, INDEX_W=8, OFFSET_W=6, LINE_W, MEM_DW, BEATS.
  - The state enum {IDLE, REQ, FILL, WRITE, RESP}.
  - The tag-SRAM entry type {valid, tag}.
- One natural sub-module, cc_line_buffer: beat counter, write-by-beat and word-select read. The top level keeps the FSM and handshakes.

Test Plan:
- Basic fill:
  - Stimulus: miss_i with tag=18'h2_ABCD, index=8'h5A, offset=6'h14; arready=1; 8 beats data=64'h0000_0001_0000_0000*k+k for k=0..7, rlast on beat 7; cpu_rready=1.
  - Required response: araddr=32'hAAF3_5680, arlen=7; one wren cycle with windex=5A and wdata_tag=19'h6ABCD; cpu_rdata is the high word of beat 2 = 32'h0000_0002.
- AR backpressure: mem_arready_i=0 for 5 cycles → mem_arvalid_o and araddr held constant all 5 cycles; exactly one AR handshake.
- R gaps and CPU stall:
  - Stimulus: rvalid toggles 1-0-1; cpu_rready low for 3 cycles.
  - Required response: line correct; cpu_rvalid and cpu_rdata stable for 3 cycles; busy_o deasserts only after the handshake.
- Early rlast: rlast on beat 3 with offset=6'h3C → cpu_rdata=0 and line bits [511:256]=0.
- Miss while busy: a second miss_i (index=8'h01) during FILL → ignored; write uses index 5A; no second AR.
- Reset mid-FILL: rst_n low after 4 beats → all outputs 0 asynchronously; after release, a new miss fills correctly with no stale data in the line.
